// File: rtl/vect_pkg.sv
// Shared vector ISA constants and types for the issue scheduler.
// Decode fields follow the RVV 1.0 major-opcode encoding.
package vect_pkg;

  localparam logic [6:0] VLOAD  = 7'b0000111;
  localparam logic [6:0] VSTORE = 7'b0100111;
  localparam logic [6:0] VARITH = 7'b1010111;

  localparam logic [2:0] OPIVV = 3'b000;
  localparam logic [2:0] OPMVV = 3'b010;
  localparam logic [2:0] OPIVI = 3'b011;
  localparam logic [2:0] OPIVX = 3'b100;
  localparam logic [2:0] OPMVX = 3'b110;

  localparam logic [5:0] VSLIDEUP   = 6'b001110;
  localparam logic [5:0] VSLIDEDOWN = 6'b001111;
  localparam logic [5:0] VADC       = 6'b010000;

  localparam logic [5:0] VREDSUM  = 6'b000000;
  localparam logic [5:0] VREDAND  = 6'b000001;
  localparam logic [5:0] VREDOR   = 6'b000010;
  localparam logic [5:0] VREDXOR  = 6'b000011;
  localparam logic [5:0] VREDMINU = 6'b000100;
  localparam logic [5:0] VREDMIN  = 6'b000101;
  localparam logic [5:0] VREDMAXU = 6'b000110;
  localparam logic [5:0] VREDMAX  = 6'b000111;

  // mop lives in funct6[1:0]; vs3 of a store shares the vd slot.
  typedef struct packed {
    logic [5:0] funct6;
    logic       vm;
    logic [4:0] vs2;
    logic [4:0] vs1;
    logic [2:0] funct3;
    logic [4:0] vd;
    logic [6:0] opcode;
  } arithm_instr_t;

  typedef enum logic [1:0] {UNIT_ARITH, UNIT_LSU, UNIT_SLDU, UNIT_NONE} unit_sel_t;

  typedef enum logic {ST_EMPTY, ST_HELD} sched_state_t;

  function automatic logic is_reduction(input logic [5:0] f6);
    return f6 inside {VREDSUM, VREDAND, VREDOR, VREDXOR,
                      VREDMINU, VREDMIN, VREDMAXU, VREDMAX};
  endfunction

endpackage

// File: rtl/v_issue_decode.sv
// Combinational classifier: target unit, source-register mask and destination
// of one vector instruction.
module v_issue_decode
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output unit_sel_t             unit_sel,
  output logic [REG_NUM-1:0]    src_mask,
  output logic                  has_vd,
  output logic [4:0]            vd
);

  arithm_instr_t f;
  logic use_vs1, use_vs2, use_vs3, use_v0;

  assign f = arithm_instr_t'(instr[31:0]);

  always_comb begin
    unit_sel = UNIT_NONE;
    case (f.opcode)
      VLOAD, VSTORE: unit_sel = UNIT_LSU;
      VARITH: begin
        if (f.funct6 inside {VSLIDEUP, VSLIDEDOWN} ||
            (f.funct6 == VADC && f.funct3 inside {OPMVV, OPMVX}) ||
            (is_reduction(f.funct6) && f.funct3 == OPMVV))
          unit_sel = UNIT_SLDU;
        else
          unit_sel = UNIT_ARITH;
      end
      default: unit_sel = UNIT_NONE;
    endcase
  end

  // The vs1 slot only names a vector register on arithmetic encodings;
  // for memory ops it is the scalar base rs1.
  always_comb begin
    use_vs1 = (f.opcode == VARITH) && (f.funct3 inside {OPIVV, OPMVV});
    use_vs2 = (unit_sel == UNIT_ARITH) || (unit_sel == UNIT_SLDU) ||
              ((unit_sel == UNIT_LSU) && f.funct6[0]);
    use_vs3 = (f.opcode == VSTORE);
    use_v0  = (unit_sel != UNIT_NONE) && !f.vm;
    for (int i = 0; i < REG_NUM; i++) begin
      src_mask[i] = (use_vs1 && f.vs1 == 5'(i)) ||
                    (use_vs2 && f.vs2 == 5'(i)) ||
                    (use_vs3 && f.vd  == 5'(i)) ||
                    (use_v0  && i == 0);
    end
  end

  assign has_vd = (unit_sel != UNIT_NONE) && (f.opcode != VSTORE);
  assign vd     = f.vd;

endmodule

// File: rtl/v_issue_sched.sv
// Vector issue scheduler: holds one IQ instruction, checks the register
// scoreboard and dispatches to ARITH/VLSU/SLDU. Optional VISSUE_STATS_EN adds counters.
module v_issue_sched
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  arith_req_o,
  input  logic                  arith_ready_i,
  output logic                  lsu_req_o,
  input  logic                  lsu_ready_i,
  output logic                  sldu_req_o,
  input  logic                  sldu_ready_i,
  input  logic                  arith_done_i,
  input  logic                  lsu_done_i,
  input  logic                  sldu_done_i,
  output logic [REG_NUM-1:0]    busy_o,
  output logic                  idle_o,
  output logic                  proto_err_o,
  output sched_state_t          state_o
`ifdef VISSUE_STATS_EN
  ,
  output logic [31:0]           issue_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  sched_state_t          state;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [REG_NUM-1:0]    busy;
  logic [2:0]            inflight;
  logic [2:0]            inflight_has_vd;
  logic [4:0]            inflight_vd [3];
  logic                  err;

  unit_sel_t          unit_sel;
  logic [REG_NUM-1:0] src_mask;
  logic               has_vd;
  logic [4:0]         vd;

  v_issue_decode #(.DATA_WIDTH(DATA_WIDTH), .REG_NUM(REG_NUM)) u_decode (
    .instr    (instr_q),
    .unit_sel (unit_sel),
    .src_mask (src_mask),
    .has_vd   (has_vd),
    .vd       (vd)
  );

  // Per-unit vectors are indexed {SLDU, LSU, ARITH}, matching unit_sel_t.
  logic [2:0] unit_oh, ready_vec, done_vec, req_vec, fire_vec;
  logic       hazard, fire, drop, advance, pop;
  logic [REG_NUM-1:0] busy_set, busy_clr;

  assign unit_oh   = {unit_sel == UNIT_SLDU, unit_sel == UNIT_LSU, unit_sel == UNIT_ARITH};
  assign ready_vec = {sldu_ready_i, lsu_ready_i, arith_ready_i};
  assign done_vec  = {sldu_done_i, lsu_done_i, arith_done_i};

  // Hazards see only registered state, so req is a pure function of flops and
  // a held instruction's req can only rise, never fall, until it fires.
  assign hazard   = (|(src_mask & busy)) || (has_vd && busy[vd]) || (|(unit_oh & inflight));
  assign req_vec  = (state == ST_HELD && !hazard) ? unit_oh : 3'b000;
  assign fire_vec = req_vec & ready_vec;
  assign fire     = |fire_vec;
  assign drop     = (state == ST_HELD) && (unit_sel == UNIT_NONE);
  assign advance  = fire || drop;
  assign pop      = instr_ready_o && instr_valid_i;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (fire && has_vd) busy_set[vd] = 1'b1;
    for (int u = 0; u < 3; u++) begin
      if (done_vec[u] && inflight[u] && inflight_has_vd[u]) busy_clr[inflight_vd[u]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_EMPTY;
      instr_q         <= '0;
      busy            <= '0;
      inflight        <= '0;
      inflight_has_vd <= '0;
      for (int u = 0; u < 3; u++) inflight_vd[u] <= '0;
      err             <= 1'b0;
    end else begin
      busy     <= (busy & ~busy_clr) | busy_set;
      inflight <= (inflight & ~done_vec) | fire_vec;
      for (int u = 0; u < 3; u++) begin
        if (fire_vec[u]) begin
          inflight_vd[u]     <= vd;
          inflight_has_vd[u] <= has_vd;
        end
      end
      if ((|(done_vec & ~inflight)) || drop) err <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (pop) begin
            instr_q <= instr_i;
            state   <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (pop) begin
            instr_q <= instr_i;
            state   <= ST_HELD;
          end else if (advance) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign instr_ready_o = (state == ST_EMPTY) || advance;
  assign instr_o       = instr_q;
  assign arith_req_o   = req_vec[0];
  assign lsu_req_o     = req_vec[1];
  assign sldu_req_o    = req_vec[2];
  assign busy_o        = busy;
  assign idle_o        = (state == ST_EMPTY) && (inflight == 3'b000);
  assign proto_err_o   = err;
  assign state_o       = state;

`ifdef VISSUE_STATS_EN
  logic [31:0] issue_cnt, stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire) issue_cnt <= issue_cnt + 32'd1;
      if (state == ST_HELD && req_vec == 3'b000) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign issue_cnt_o = issue_cnt;
  assign stall_cnt_o = stall_cnt;
`endif

endmodule
